lsu_responder: RTL and testbench
================================

LSU_RESPONDER -- requirements
Module: lsu_responder

Interface
REQ-001 Parameter ADDR_WIDTH_D, default 10: RAM word-address width, giving 2^ADDR_WIDTH_D 32-bit words.
REQ-002 Parameter TIMER_BASE, default 32'h0200_0000: byte base address of the timer register window.
REQ-003 Port clk  in  1: clock; all state updates on the rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port rready_cpu  in  1: read request from the core; held until served.
REQ-006 Port rvalid_cpu  out  1: read response valid; one-cycle pulse.
REQ-007 Port wvalid_cpu  in  1: write request from the core; held until served.
REQ-008 Port wready_cpu  out  1: write accepted; one-cycle pulse.
REQ-009 Port strb_cpu  in  4: byte write strobes (bit i selects byte i).
REQ-010 Port addr_cpu  in  32: byte address.
REQ-011 Port data_cpu_o  in  32: write data from the core.
REQ-012 Port data_cpu_i  out  32: read data to the core.
REQ-013 Port timer_irq  out  1: machine timer interrupt level.

Function
REQ-014 Address decode SHALL be as follows:
- RAM region when addr_cpu[31:ADDR_WIDTH_D+2]==0; word index is addr_cpu[ADDR_WIDTH_D+1:2].
- TIMER region when addr_cpu[31:4]==TIMER_BASE[31:4].
- Any other address is UNMAPPED.
REQ-015 The FSM SHALL have three states: IDLE, RESP, HOLD.
- IDLE: if wvalid_cpu is high, accept the write; else if rready_cpu is high, accept the read; go to RESP.
- RESP: lasts exactly one cycle, then go to HOLD.
- HOLD: remain until rready_cpu and wvalid_cpu are both low, then go to IDLE.
REQ-016 A write SHALL take priority when wvalid_cpu and rready_cpu are both high in IDLE; the read is not served in that transaction.
REQ-017 A write SHALL be committed on the accepting edge, and wready_cpu SHALL be high only during RESP, giving 1-cycle latency.
REQ-018 For a read, rvalid_cpu SHALL be high only during RESP, and data_cpu_i SHALL be the registered read data in RESP.
REQ-019 data_cpu_i SHALL hold its last value outside RESP.
REQ-020 RAM writes SHALL update only the bytes whose strb bit is 1; strb==0 completes the handshake with no change.
REQ-021 Timer registers:
- +0x0: mtime[31:0].
- +0x4: mtime[63:32].
- +0x8: mtimecmp[31:0].
- +0xC: mtimecmp[63:32].
- Strobes are honoured per byte.
REQ-022 mtime SHALL increment by 1 every clock and wrap from 2^64-1 to 0.
REQ-023 When a CPU write to mtime coincides with an increment, the written bytes SHALL take the written value and the other bytes the incremented value.
REQ-024 timer_irq SHALL be registered, equal to (mtime >= mtimecmp) as evaluated one cycle earlier, compared unsigned over 64 bits.
REQ-025 UNMAPPED reads SHALL return 32'h0; UNMAPPED writes SHALL be ignored; both SHALL still complete the handshake (no hang).
REQ-026 Reads of the two mtime halves are non-atomic; software re-reads the high half to detect a carry.

Reset
REQ-027 Asserting rst_n low at any time, including mid-transaction, SHALL force:
- FSM to IDLE;
- rvalid_cpu=0, wready_cpu=0, data_cpu_i=0, timer_irq=0;
- mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
REQ-028 RAM contents are not reset.
REQ-029 After release, the first request SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-030 Macro LSU_RESPONDER_TIMER_EN defined: the timer is implemented as in REQ-021 to REQ-024.
REQ-031 Macro LSU_RESPONDER_TIMER_EN undefined:
- no timer registers are synthesized;
- the TIMER window decodes as UNMAPPED;
- timer_irq is constant 0.

Structure
REQ-032 Package lsu_map_pkg SHALL hold:
- TIMER offset constants (0x0, 0x4, 0x8, 0xC);
- the region enum (RAM, TIMER, UNMAPPED);
- the FSM state enum;
- the MTIMECMP reset constant.
REQ-033 Sub-module dmem_ram SHALL hold the RAM: synchronous read, byte-enable write, parameter ADDR_WIDTH_D.
REQ-034 Decode, FSM and timer SHALL stay in lsu_responder.

Verification
REQ-035 Write addr 0x10, data 0xA5A5_5A5A, strb 0xF; then read 0x10 -> wready pulses 1 cycle after accept; rvalid pulses 1 cycle after accept; data_cpu_i=0xA5A5_5A5A.
REQ-036 Write 0x11223344 strb 0xF, then 0xFFFF_FFFF strb 0x2, to addr 0x20; then read 0x20 -> 0x1122FF44.
REQ-037 Requests held high for 5 cycles -> exactly one rvalid/wready pulse; the next accept occurs only after the requests drop.
REQ-038 wvalid and rready asserted together in IDLE -> write committed, wready pulses, no rvalid that transaction.
REQ-039 Timer (LSU_RESPONDER_TIMER_EN defined): write mtimecmp_hi=0 and mtimecmp_lo=50 after reset -> timer_irq rises in the cycle after mtime reaches 50; undefined build -> timer_irq stays 0.
REQ-040 Read 0x4000_0000 -> rvalid pulses with data 0.
REQ-041 rst_n low during RESP -> rvalid=0 immediately; the FSM is in IDLE after release.

Source files
------------

// File: rtl/lsu_map_pkg.sv
// ------------------------------------------------------------------
// lsu_map_pkg: address-map constants, enums and byte-merge helper.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package lsu_map_pkg;

   localparam logic [3:0]  TMR_MTIME_LO    = 4'h0;
   localparam logic [3:0]  TMR_MTIME_HI    = 4'h4;
   localparam logic [3:0]  TMR_MTIMECMP_LO = 4'h8;
   localparam logic [3:0]  TMR_MTIMECMP_HI = 4'hC;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      REGION_RAM      = 2'd0,
      REGION_TIMER    = 2'd1,
      REGION_UNMAPPED = 2'd2
   } region_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RESP = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
      logic [31:0] result;
      for (int i = 0; i < 4; i++) begin
         result[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ------------------------------------------------------------------
// dmem_ram: 32-bit word RAM, synchronous read, byte-enable write.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module dmem_ram #(
   parameter int ADDR_WIDTH_D = 10
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic                    re,
   input  logic [3:0]              be,
   input  logic [ADDR_WIDTH_D-1:0] addr,
   input  logic [31:0]             wdata,
   output logic [31:0]             rdata
);

   logic [31:0] mem [0:(1 << ADDR_WIDTH_D)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/lsu_responder.sv
// ------------------------------------------------------------------
// lsu_responder: core load/store responder for RAM and an mtime timer
// (timer built only with LSU_RESPONDER_TIMER_EN).  Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module lsu_responder
   import lsu_map_pkg::*;
#(
   parameter int          ADDR_WIDTH_D = 10,
   parameter logic [31:0] TIMER_BASE   = 32'h0200_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rready_cpu,
   output logic        rvalid_cpu,
   input  logic        wvalid_cpu,
   output logic        wready_cpu,
   input  logic [3:0]  strb_cpu,
   input  logic [31:0] addr_cpu,
   input  logic [31:0] data_cpu_o,
   output logic [31:0] data_cpu_i,
   output logic        timer_irq
);

   state_e      state, state_nx;
   region_e     region, region_q;
   logic        accept;
   logic        is_write_q;
   logic        ram_hit, timer_win;
   logic        ram_we, ram_re;
   logic [31:0] ram_rdata;
   logic [31:0] timer_rdata_q;
   logic [31:0] read_mux;
   logic [31:0] hold_data;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = ^addr_cpu[1:0];

   assign ram_hit   = (addr_cpu >> (ADDR_WIDTH_D + 2)) == 32'd0;
   assign timer_win = addr_cpu[31:4] == TIMER_BASE[31:4];

   always_comb begin
      region = REGION_UNMAPPED;
      if (ram_hit) begin
         region = REGION_RAM;
      end
`ifdef LSU_RESPONDER_TIMER_EN
      else if (timer_win) begin
         region = REGION_TIMER;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (wvalid_cpu || rready_cpu) begin
               accept   = 1'b1;
               state_nx = ST_RESP;
            end
         end
         ST_RESP: state_nx = ST_HOLD;
         ST_HOLD: begin
            if (!wvalid_cpu && !rready_cpu) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Write wins over a simultaneous read; the read must be re-requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_write_q <= 1'b0;
         region_q   <= REGION_UNMAPPED;
         hold_data  <= 32'h0;
      end else begin
         if (accept) begin
            is_write_q <= wvalid_cpu;
            region_q   <= region;
         end
         if (rvalid_cpu) begin
            hold_data <= read_mux;
         end
      end
   end

   assign ram_we = accept && wvalid_cpu && (region == REGION_RAM);
   assign ram_re = accept && !wvalid_cpu && (region == REGION_RAM);

   dmem_ram #(
      .ADDR_WIDTH_D (ADDR_WIDTH_D)
   ) u_dmem_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .be    (strb_cpu),
      .addr  (addr_cpu[ADDR_WIDTH_D+1:2]),
      .wdata (data_cpu_o),
      .rdata (ram_rdata)
   );

   always_comb begin
      read_mux = 32'h0;
      case (region_q)
         REGION_RAM:   read_mux = ram_rdata;
         REGION_TIMER: read_mux = timer_rdata_q;
         default:      read_mux = 32'h0;
      endcase
   end

   assign rvalid_cpu = (state == ST_RESP) && !is_write_q;
   assign wready_cpu = (state == ST_RESP) && is_write_q;
   assign data_cpu_i = rvalid_cpu ? read_mux : hold_data;

`ifdef LSU_RESPONDER_TIMER_EN
   logic [63:0] mtime, mtime_inc, mtime_nx;
   logic [63:0] mtimecmp, mtimecmp_nx;
   logic [3:0]  tmr_off;
   logic        tmr_we, tmr_re;
   logic        unused_timer_win;

   assign unused_timer_win = timer_win;
   assign tmr_off   = {addr_cpu[3:2], 2'b00};
   assign tmr_we    = accept && wvalid_cpu && (region == REGION_TIMER);
   assign tmr_re    = accept && !wvalid_cpu && (region == REGION_TIMER);
   assign mtime_inc = mtime + 64'd1;

   // Written bytes override the increment; unwritten bytes keep counting.
   always_comb begin
      mtime_nx    = mtime_inc;
      mtimecmp_nx = mtimecmp;
      if (tmr_we) begin
         case (tmr_off)
            TMR_MTIME_LO:    mtime_nx[31:0]     = merge_bytes(mtime_inc[31:0],  data_cpu_o, strb_cpu);
            TMR_MTIME_HI:    mtime_nx[63:32]    = merge_bytes(mtime_inc[63:32], data_cpu_o, strb_cpu);
            TMR_MTIMECMP_LO: mtimecmp_nx[31:0]  = merge_bytes(mtimecmp[31:0],   data_cpu_o, strb_cpu);
            TMR_MTIMECMP_HI: mtimecmp_nx[63:32] = merge_bytes(mtimecmp[63:32],  data_cpu_o, strb_cpu);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime         <= 64'd0;
         mtimecmp      <= MTIMECMP_RST;
         timer_irq     <= 1'b0;
         timer_rdata_q <= 32'h0;
      end else begin
         mtime     <= mtime_nx;
         mtimecmp  <= mtimecmp_nx;
         timer_irq <= (mtime >= mtimecmp);
         if (tmr_re) begin
            case (tmr_off)
               TMR_MTIME_LO:    timer_rdata_q <= mtime[31:0];
               TMR_MTIME_HI:    timer_rdata_q <= mtime[63:32];
               TMR_MTIMECMP_LO: timer_rdata_q <= mtimecmp[31:0];
               TMR_MTIMECMP_HI: timer_rdata_q <= mtimecmp[63:32];
               default:         timer_rdata_q <= 32'h0;
            endcase
         end
      end
   end
`else
   logic unused_timer_win;

   assign unused_timer_win = timer_win;
   assign timer_rdata_q    = 32'h0;
   assign timer_irq        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lsu_responder.sv
// ------------------------------------------------------------------
// tb_lsu_responder: directed self-checking bench for lsu_responder.
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lsu_responder;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        rready_cpu = 1'b0;
   logic        wvalid_cpu = 1'b0;
   logic [3:0]  strb_cpu   = 4'h0;
   logic [31:0] addr_cpu   = 32'h0;
   logic [31:0] data_cpu_o = 32'h0;
   logic        rvalid_cpu;
   logic        wready_cpu;
   logic [31:0] data_cpu_i;
   logic        timer_irq;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lsu_responder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rready_cpu (rready_cpu),
      .rvalid_cpu (rvalid_cpu),
      .wvalid_cpu (wvalid_cpu),
      .wready_cpu (wready_cpu),
      .strb_cpu   (strb_cpu),
      .addr_cpu   (addr_cpu),
      .data_cpu_o (data_cpu_o),
      .data_cpu_i (data_cpu_i),
      .timer_irq  (timer_irq)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Accept edge, RESP check, drop request, HOLD check, back to IDLE.
   task automatic do_write(input string tag, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
      addr_cpu   = a;
      data_cpu_o = d;
      strb_cpu   = s;
      wvalid_cpu = 1'b1;
      tick;
      chk1({tag, "_wready"}, wready_cpu, 1'b1);
      chk1({tag, "_no_rvalid"}, rvalid_cpu, 1'b0);
      wvalid_cpu = 1'b0;
      tick;
      chk1({tag, "_wready_drop"}, wready_cpu, 1'b0);
      tick;
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr_cpu   = a;
      rready_cpu = 1'b1;
      tick;
      chk1({tag, "_rvalid"}, rvalid_cpu, 1'b1);
      chk32({tag, "_data"}, data_cpu_i, exp);
      rready_cpu = 1'b0;
      tick;
      chk1({tag, "_rvalid_drop"}, rvalid_cpu, 1'b0);
      chk32({tag, "_data_hold"}, data_cpu_i, exp);
      tick;
   endtask

   initial begin
      int pulses;

      // Reset state
      tick;
      tick;
      chk1("rst_rvalid", rvalid_cpu, 1'b0);
      chk1("rst_wready", wready_cpu, 1'b0);
      chk32("rst_data", data_cpu_i, 32'h0);
      chk1("rst_irq", timer_irq, 1'b0);
      rst_n = 1'b1;

      // Basic write/read, first request right after release
      do_write("w10", 32'h10, 32'hA5A5_5A5A, 4'hF);
      do_read("r10", 32'h10, 32'hA5A5_5A5A);

      // Byte strobes
      do_write("w20a", 32'h20, 32'h1122_3344, 4'hF);
      do_write("w20b", 32'h20, 32'hFFFF_FFFF, 4'h2);
      do_read("r20", 32'h20, 32'h1122_FF44);

      // strb==0 handshake leaves RAM unchanged
      do_write("w10z", 32'h10, 32'h0000_0000, 4'h0);
      do_read("r10z", 32'h10, 32'hA5A5_5A5A);

      // Read held for 5 cycles gives exactly one pulse
      pulses     = 0;
      addr_cpu   = 32'h20;
      rready_cpu = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (rvalid_cpu) pulses++;
      end
      chk32("hold_read_pulses", 32'(pulses), 32'd1);
      rready_cpu = 1'b0;
      tick;

      // Write held for 5 cycles gives exactly one pulse
      pulses     = 0;
      addr_cpu   = 32'h30;
      data_cpu_o = 32'hDEAD_BEEF;
      strb_cpu   = 4'hF;
      wvalid_cpu = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (wready_cpu) pulses++;
      end
      chk32("hold_write_pulses", 32'(pulses), 32'd1);
      wvalid_cpu = 1'b0;
      tick;
      do_read("r30", 32'h30, 32'hDEAD_BEEF);

      // Simultaneous write and read: write wins
      addr_cpu   = 32'h40;
      data_cpu_o = 32'h0BAD_F00D;
      strb_cpu   = 4'hF;
      wvalid_cpu = 1'b1;
      rready_cpu = 1'b1;
      tick;
      chk1("both_wready", wready_cpu, 1'b1);
      chk1("both_no_rvalid", rvalid_cpu, 1'b0);
      chk32("both_data_hold", data_cpu_i, 32'hDEAD_BEEF);
      wvalid_cpu = 1'b0;
      rready_cpu = 1'b0;
      tick;
      chk1("both_no_rvalid_hold", rvalid_cpu, 1'b0);
      tick;
      do_read("r40", 32'h40, 32'h0BAD_F00D);

      // Unmapped accesses complete; aliasing address does not hit RAM
      do_read("runm", 32'h4000_0000, 32'h0);
      do_write("wunm", 32'h4000_0000, 32'h1234_5678, 4'hF);
      do_read("runm2", 32'h4000_0000, 32'h0);
      do_write("walias", 32'h0000_1010, 32'h1234_5678, 4'hF);
      do_read("r10alias", 32'h10, 32'hA5A5_5A5A);

      // Reset asserted during RESP
      addr_cpu   = 32'h10;
      rready_cpu = 1'b1;
      tick;
      chk1("midrst_rvalid_pre", rvalid_cpu, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("midrst_rvalid", rvalid_cpu, 1'b0);
      chk1("midrst_wready", wready_cpu, 1'b0);
      chk32("midrst_data", data_cpu_i, 32'h0);
      chk1("midrst_irq", timer_irq, 1'b0);
      rready_cpu = 1'b0;
      tick;
      rst_n = 1'b1;

`ifdef LSU_RESPONDER_TIMER_EN
      // Edge n after release leaves mtime == n
      do_write("wcmphi", 32'h0200_000C, 32'h0, 4'hF);               // edges 1-3
      do_write("wcmplo", 32'h0200_0008, 32'd50, 4'hF);              // edges 4-6
      do_read("rmtlo", 32'h0200_0000, 32'd6);                       // accept edge 7
      chk1("irq_early", timer_irq, 1'b0);
      repeat (41) tick;                                             // edge 50
      chk1("irq_at50", timer_irq, 1'b0);
      tick;                                                         // edge 51
      chk1("irq_rise", timer_irq, 1'b1);
      do_read("rcmplo", 32'h0200_0008, 32'd50);                     // edges 52-54
      do_write("wmtlo", 32'h0200_0000, 32'hFFFF_FFFE, 4'hF);        // edges 55-57
      do_read("rmthi", 32'h0200_0004, 32'h1);                       // accept edge 58
      do_read("rmtlo2", 32'h0200_0000, 32'd3);                      // accept edge 61
      do_write("wcmphi2", 32'h0200_000C, 32'hAABB_CCDD, 4'h4);      // edges 64-66
      chk1("irq_fall", timer_irq, 1'b0);
      do_read("rcmphi", 32'h0200_000C, 32'h00BB_0000);              // edges 67-69
      do_write("wmthi", 32'h0200_0004, 32'h7F00_0000, 4'h8);        // accept edge 70
      do_read("rmthi2", 32'h0200_0004, 32'h7F00_0001);              // accept edge 73
      do_read("rmtlo3", 32'h0200_0000, 32'd18);                     // accept edge 76
      chk1("irq_high", timer_irq, 1'b1);
`else
      do_read("r10post", 32'h10, 32'hA5A5_5A5A);
      do_read("rtmr", 32'h0200_0000, 32'h0);
      do_write("wtmr", 32'h0200_0008, 32'd0, 4'hF);
      do_read("rtmrcmp", 32'h0200_0008, 32'h0);
      repeat (60) tick;
      chk1("irq_off", timer_irq, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
